// File: rtl/div_seq.sv
// Sequential signed divider: restoring division on operand magnitudes, one quotient bit
// per cycle, then sign correction. Define DIV_ZERO_TRAP_EN to trap division by zero.
module div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
`ifdef DIV_ZERO_TRAP_EN
  output logic             div_zero,
`endif
  output logic [1:0]       dbg_state_o
);

  // Handshake: start is sampled only in IDLE; busy is high from the acceptance
  // edge to the edge that writes hi/lo, and done pulses for the cycle after that.
  typedef enum logic [1:0] {S_IDLE, S_INIT, S_LOOP, S_FIX} state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             sign_q_q, sign_q_d, sign_r_q, sign_r_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d, done_q, done_d;
`ifdef DIV_ZERO_TRAP_EN
  logic             zero_q, zero_d;
  logic             dz_q, dz_d;
`endif

  // Partial remainder after the shift needs one extra bit before the trial subtract.
  logic [WIDTH:0]   shl;
  logic             fits;
  logic [WIDTH-1:0] rem_sub;

  assign shl     = {rem_q, quo_q[WIDTH-1]};
  assign fits    = (shl >= {1'b0, dvs_q});
  assign rem_sub = shl[WIDTH-1:0] - dvs_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef DIV_ZERO_TRAP_EN
      zero_q   <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef DIV_ZERO_TRAP_EN
      zero_q   <= zero_d;
      dz_q     <= dz_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
    zero_d   = zero_q;
    dz_d     = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        rem_d    = '0;
        quo_d    = a_q[WIDTH-1] ? -a_q : a_q;
        dvs_d    = b_q[WIDTH-1] ? -b_q : b_q;
        sign_q_d = a_q[WIDTH-1] ^ b_q[WIDTH-1];
        sign_r_d = a_q[WIDTH-1];
        cnt_d    = '0;
`ifdef DIV_ZERO_TRAP_EN
        zero_d   = (b_q == '0);
        state_d  = (b_q == '0) ? S_FIX : S_LOOP;
`else
        state_d  = S_LOOP;
`endif
      end
      S_LOOP: begin
        rem_d = fits ? rem_sub : shl[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
`ifdef DIV_ZERO_TRAP_EN
        // A trapped divide leaves the previous result in hi/lo.
        if (zero_q) begin
          dz_d = 1'b1;
        end else begin
          lo_d = sign_q_q ? -quo_q : quo_q;
          hi_d = sign_r_q ? -rem_q : rem_q;
        end
`else
        lo_d = sign_q_q ? -quo_q : quo_q;
        hi_d = sign_r_q ? -rem_q : rem_q;
`endif
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef DIV_ZERO_TRAP_EN
  assign div_zero    = dz_q;
`endif
  assign dbg_state_o = state_q;

endmodule
